// File: rtl/bankp_rom_loader.sv
// Download sequencer: splits 16-bit ioctl words into byte writes, decodes the
// four BankPanic ROM regions and gates the core reset on a complete image.
module bankp_rom_loader #(
  parameter logic [16:0] R1_BASE = 17'h0E000,
  parameter logic [16:0] R2_BASE = 17'h12000,
  parameter logic [16:0] R3_BASE = 17'h1E000,
  parameter logic [16:0] IMG_END = 17'h1E220
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        wr_en,
  output logic [3:0]  wr_region,
  output logic [16:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        core_reset,
  output logic        rom_loaded,
  output logic        load_done,
  output logic [1:0]  err
);

  localparam int unsigned AW  = 17;
  localparam int unsigned FAW = 27;
  localparam int unsigned DEC = 1 + 4 + AW;

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t           state, state_nx;
  logic [FAW-1:0]   addr_q;
  logic [7:0]       data_hi_q;
  logic [AW-1:0]    cnt, cnt_nx, cnt_base;
  logic             dl_q, close_pend, pend_nx;
  logic             dl_rise, dl_fall, close;
  logic             accept, byte_go, proto_err, wr_ok, range_err;
  logic [FAW-1:0]   byte_addr;
  logic [7:0]       byte_data;
  logic [DEC-1:0]   dec;
  logic             wait_nx, rom_loaded_nx;
  logic [1:0]       err_nx;

  // {in_range, one-hot region, region-relative offset} for one byte address
  function automatic logic [DEC-1:0] decode(input logic [FAW-1:0] a);
    logic [AW-1:0] ba;
    ba = a[AW-1:0];
    if (a[FAW-1:AW] != '0 || ba >= IMG_END) decode = '0;
    else if (ba < R1_BASE)                  decode = {1'b1, 4'b0001, ba};
    else if (ba < R2_BASE)                  decode = {1'b1, 4'b0010, AW'(ba - R1_BASE)};
    else if (ba < R3_BASE)                  decode = {1'b1, 4'b0100, AW'(ba - R2_BASE)};
    else                                    decode = {1'b1, 4'b1000, AW'(ba - R3_BASE)};
  endfunction

  // Next-state, byte selection and status bookkeeping
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    byte_go   = 1'b0;
    byte_addr = '0;
    byte_data = '0;
    proto_err = 1'b0;
    wait_nx   = ioctl_wait;
    case (state)
      IDLE: begin
        if (ioctl_wr && ioctl_download) begin
          state_nx  = LO;
          accept    = 1'b1;
          byte_go   = 1'b1;
          byte_addr = ioctl_addr;
          byte_data = ioctl_dout[7:0];
          wait_nx   = 1'b1;
        end
      end
      LO: begin
        state_nx  = HI;
        byte_go   = 1'b1;
        byte_addr = addr_q | FAW'(1);
        byte_data = data_hi_q;
        proto_err = ioctl_wr;
      end
      HI: begin
        state_nx  = IDLE;
        wait_nx   = 1'b0;
        proto_err = ioctl_wr;
      end
      default: state_nx = IDLE;
    endcase

    dec       = decode(byte_addr);
    wr_ok     = byte_go & dec[DEC-1];
    range_err = byte_go & ~dec[DEC-1];

    dl_rise = ioctl_download & ~dl_q;
    dl_fall = ~ioctl_download & dl_q;
    // A close arriving mid-word waits until the word's bytes are out
    close   = (state == IDLE) && (dl_fall || close_pend);
    pend_nx = ~dl_rise & ~close & (close_pend | dl_fall);

    cnt_base = dl_rise ? '0 : cnt;
    cnt_nx   = (wr_ok && cnt_base != '1) ? AW'(cnt_base + AW'(1)) : cnt_base;

    err_nx        = (dl_rise ? 2'b00 : err) | {1'b0, range_err | proto_err};
    rom_loaded_nx = dl_rise ? 1'b0 : rom_loaded;
    if (close) begin
      if (cnt >= IMG_END) rom_loaded_nx = 1'b1;
      else                err_nx[1]     = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_hi_q  <= '0;
      cnt        <= '0;
      dl_q       <= 1'b0;
      close_pend <= 1'b0;
      ioctl_wait <= 1'b0;
      wr_en      <= 1'b0;
      wr_region  <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_reset <= 1'b1;
      rom_loaded <= 1'b0;
      load_done  <= 1'b0;
      err        <= '0;
    end else begin
      state      <= state_nx;
      if (accept) begin
        addr_q    <= ioctl_addr;
        data_hi_q <= ioctl_dout[15:8];
      end
      cnt        <= cnt_nx;
      dl_q       <= ioctl_download;
      close_pend <= pend_nx;
      ioctl_wait <= wait_nx;
      wr_en      <= wr_ok;
      if (wr_ok) begin
        wr_region <= dec[DEC-2:AW];
        wr_addr   <= dec[AW-1:0];
        wr_data   <= byte_data;
      end
      core_reset <= ioctl_download | ~rom_loaded_nx;
      rom_loaded <= rom_loaded_nx;
      load_done  <= close;
      err        <= err_nx;
    end
  end

endmodule

// File: tb/tb_bankp_rom_loader.sv
// Directed bench: default-sized loader for decode/protocol cases, a shrunken
// instance for a complete-image download.
module tb_bankp_rom_loader;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset, ioctl_download, ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;

  logic        ioctl_wait, wr_en, core_reset, rom_loaded, load_done;
  logic [3:0]  wr_region;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  err;

  logic        s_ioctl_wait, s_wr_en, s_core_reset, s_rom_loaded, s_load_done;
  logic [3:0]  s_wr_region;
  logic [16:0] s_wr_addr;
  logic [7:0]  s_wr_data;
  logic [1:0]  s_err;

  bankp_rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .wr_en(wr_en), .wr_region(wr_region),
    .wr_addr(wr_addr), .wr_data(wr_data), .core_reset(core_reset),
    .rom_loaded(rom_loaded), .load_done(load_done), .err(err)
  );

  bankp_rom_loader #(
    .R1_BASE(17'h00040), .R2_BASE(17'h00080), .R3_BASE(17'h000C0), .IMG_END(17'h00100)
  ) dut_s (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(s_ioctl_wait), .wr_en(s_wr_en), .wr_region(s_wr_region),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .core_reset(s_core_reset),
    .rom_loaded(s_rom_loaded), .load_done(s_load_done), .err(s_err)
  );

  int checks = 0;
  int errors = 0;
  int nwr = 0;
  int nswr = 0;
  logic [28:0] wq[$];
  int n0, n1, n2;

  // Byte-write monitor, sampled just after each rising edge
  always @(posedge clk_sys) begin
    #1;
    if (wr_en) begin
      nwr = nwr + 1;
      wq.push_back({wr_region, wr_addr, wr_data});
    end
    if (s_wr_en) nswr = nswr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [26:0] a, input logic [15:0] d);
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_wait",   32'(ioctl_wait), 32'd0);
    chk("rst_wr_en",  32'(wr_en), 32'd0);
    chk("rst_region", 32'(wr_region), 32'd0);
    chk("rst_addr",   32'(wr_addr), 32'd0);
    chk("rst_data",   32'(wr_data), 32'd0);
    chk("rst_core",   32'(core_reset), 32'd1);
    chk("rst_loaded", 32'(rom_loaded), 32'd0);
    chk("rst_done",   32'(load_done), 32'd0);
    chk("rst_err",    32'(err), 32'd0);
    reset = 1'b0;

    // Boundary word, with cycle-exact timing
    @(negedge clk_sys); ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    @(negedge clk_sys); ioctl_wr = 1'b1; ioctl_addr = 27'h0DFFE; ioctl_dout = 16'hBBAA;
    @(negedge clk_sys); ioctl_wr = 1'b0;
    chk("t1_wait",  32'(ioctl_wait), 32'd1);
    chk("t1_wr_en", 32'(wr_en), 32'd1);
    @(negedge clk_sys);
    chk("t2_wait",  32'(ioctl_wait), 32'd1);
    chk("t2_wr_en", 32'(wr_en), 32'd1);
    @(negedge clk_sys);
    chk("t3_wait",  32'(ioctl_wait), 32'd0);
    chk("t3_wr_en", 32'(wr_en), 32'd0);
    chk("t3_hold",  32'(wr_data), 32'h0BB);
    send_word(27'h0E000, 16'hDDCC);
    @(negedge clk_sys);
    chk("bnd_count", 32'(wq.size()), 32'd4);
    if (wq.size() >= 4) begin
      chk("bnd_b0", 32'(wq[0]), 32'({4'b0001, 17'h0DFFE, 8'hAA}));
      chk("bnd_b1", 32'(wq[1]), 32'({4'b0001, 17'h0DFFF, 8'hBB}));
      chk("bnd_b2", 32'(wq[2]), 32'({4'b0010, 17'h00000, 8'hCC}));
      chk("bnd_b3", 32'(wq[3]), 32'({4'b0010, 17'h00001, 8'hDD}));
    end
    chk("bnd_err", 32'(err), 32'd0);

    // Back-to-back strobe: second word dropped
    @(negedge clk_sys); ioctl_wr = 1'b1; ioctl_addr = 27'h00100; ioctl_dout = 16'h1234;
    @(negedge clk_sys); ioctl_addr = 27'h00200; ioctl_dout = 16'h5678;
    @(negedge clk_sys); ioctl_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("b2b_count", 32'(nwr), 32'd6);
    chk("b2b_err",   32'(err), 32'd1);
    chk("b2b_addr",  32'(wr_addr), 32'h00101);
    chk("b2b_data",  32'(wr_data), 32'h12);

    // Close of a 6-byte image
    @(negedge clk_sys); ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("c1_done",   32'(load_done), 32'd1);
    chk("c1_err",    32'(err), 32'd3);
    chk("c1_loaded", 32'(rom_loaded), 32'd0);
    chk("c1_core",   32'(core_reset), 32'd1);
    @(negedge clk_sys);
    chk("c1_pulse",  32'(load_done), 32'd0);

    // New download clears err; out-of-range words
    @(negedge clk_sys); ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("dl_err_clr", 32'(err), 32'd0);
    n1 = nwr;
    send_word(27'h1E220, 16'hEEEE);
    send_word(27'h20000, 16'hFFFF);
    @(negedge clk_sys);
    chk("ovf_count", 32'(nwr), 32'(n1));
    chk("ovf_err",   32'(err), 32'd1);

    // Short image: 0x100 words
    for (int i = 0; i < 256; i++) send_word(27'(2 * i), 16'(i));
    @(negedge clk_sys);
    chk("short_count", 32'(nwr), 32'(n1 + 512));
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("short_done",   32'(load_done), 32'd1);
    chk("short_loaded", 32'(rom_loaded), 32'd0);
    chk("short_err",    32'(err), 32'd3);
    repeat (3) @(negedge clk_sys);
    chk("short_core",   32'(core_reset), 32'd1);

    // Complete image on the small instance; close arrives mid-word
    @(negedge clk_sys); ioctl_download = 1'b1;
    @(negedge clk_sys);
    n0 = nswr;
    for (int i = 0; i < 127; i++) send_word(27'(2 * i), {8'(2 * i + 1), 8'(2 * i)});
    @(negedge clk_sys); ioctl_wr = 1'b1; ioctl_addr = 27'h000FE; ioctl_dout = 16'hFFFE;
    @(negedge clk_sys); ioctl_wr = 1'b0; ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("full_defer1", 32'(s_load_done), 32'd0);
    @(negedge clk_sys);
    chk("full_defer2", 32'(s_load_done), 32'd0);
    @(negedge clk_sys);
    chk("full_done",   32'(s_load_done), 32'd1);
    chk("full_loaded", 32'(s_rom_loaded), 32'd1);
    chk("full_core",   32'(s_core_reset), 32'd0);
    chk("full_err",    32'(s_err), 32'd0);
    chk("full_count",  32'(nswr - n0), 32'd256);
    chk("full_region", 32'(s_wr_region), 32'h8);
    chk("full_addr",   32'(s_wr_addr), 32'h0003F);
    chk("full_data",   32'(s_wr_data), 32'hFF);

    // Reset between the two bytes of a word
    @(negedge clk_sys); ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    n2 = nwr;
    @(negedge clk_sys); ioctl_wr = 1'b1; ioctl_addr = 27'h00040; ioctl_dout = 16'h4321;
    @(negedge clk_sys); ioctl_wr = 1'b0; reset = 1'b1;
    chk("mid_lo", 32'(wr_en), 32'd1);
    @(negedge clk_sys); reset = 1'b0;
    chk("mid_wait",   32'(ioctl_wait), 32'd0);
    chk("mid_wr_en",  32'(wr_en), 32'd0);
    chk("mid_core",   32'(core_reset), 32'd1);
    chk("mid_loaded", 32'(rom_loaded), 32'd0);
    @(negedge clk_sys);
    chk("mid_count",  32'(nwr), 32'(n2 + 1));
    send_word(27'h00050, 16'h0A0B);
    chk("mid_idle",   32'(nwr), 32'(n2 + 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
